// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex display driver for NUM_DIGITS common-anode digits.
// Content is captured into a pending buffer by load and only committed to the
// displayed buffer at a frame boundary, so a frame never mixes old and new data.
// Supports per-digit decimal points, per-digit blinking and leading-zero blanking.
module seg7_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    busy
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Hex nibble to segments g..a, active-low (1 = segment off).
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'b1000000;
      4'h1:    hex_decode = 7'b1111001;
      4'h2:    hex_decode = 7'b0100100;
      4'h3:    hex_decode = 7'b0110000;
      4'h4:    hex_decode = 7'b0011001;
      4'h5:    hex_decode = 7'b0010010;
      4'h6:    hex_decode = 7'b0000010;
      4'h7:    hex_decode = 7'b1111000;
      4'h8:    hex_decode = 7'b0000000;
      4'h9:    hex_decode = 7'b0010000;
      4'hA:    hex_decode = 7'b0001000;
      4'hB:    hex_decode = 7'b0000011;
      4'hC:    hex_decode = 7'b1000110;
      4'hD:    hex_decode = 7'b0100001;
      4'hE:    hex_decode = 7'b0000110;
      4'hF:    hex_decode = 7'b0001110;
      default: hex_decode = 7'b1111111;
    endcase
  endfunction

  logic [DIV_W-1:0]        div;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    frame_end;
  logic [4*NUM_DIGITS-1:0] pending_val;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic                    active_valid;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_on;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    suppress;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign tick      = (div == DIV_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Slot divider and digit index; a reset always restarts at digit 0 with a full slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else begin
      if (tick) begin
        div <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Pending/active double buffer; commit happens only at a frame boundary.
  // A load on the boundary commits the previous pending data and keeps busy set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_val  <= '0;
      pending_dp   <= '0;
      active_val   <= '0;
      active_dp    <= '0;
      active_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (frame_end && busy) begin
        active_val   <= pending_val;
        active_dp    <= pending_dp;
        active_valid <= 1'b1;
      end
      if (load) begin
        pending_val <= value;
        pending_dp  <= dp;
        busy        <= 1'b1;
      end else if (frame_end) begin
        busy <= 1'b0;
      end
    end
  end

  // Blink phase toggles after every BLINK_FRAMES frame boundaries, starting in "on".
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  // Leading-zero mask: blank from the top while nibble and dp are both zero; digit 0 always shown.
  always_comb begin
    lz_mask  = '0;
    suppress = lz_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (suppress && (active_val[4*i +: 4] == 4'h0) && !active_dp[i]) begin
        lz_mask[i] = 1'b1;
      end else begin
        suppress = 1'b0;
      end
    end
  end

  // Next seg/an pair built from one index value so both always describe the same digit.
  always_comb begin
    cur_nib   = active_val[4*idx +: 4];
    cur_dp    = active_dp[idx];
    cur_blank = !active_valid || lz_mask[idx] || (!blink_on && blink_en[idx]);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next[i] = cur_blank || (idx != IDX_W'(i));
    end
    if (cur_blank) begin
      seg_next = 8'hFF;
    end else begin
      seg_next = {~cur_dp, hex_decode(cur_nib)};
    end
  end

  // Registered display outputs, dark after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed testbench for seg7_scan with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  blink_en = 4'b0000;
  logic        lz_en = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int errors = 0;
  int checks = 0;

  seg7_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .value   (value),
    .dp      (dp),
    .blink_en(blink_en),
    .lz_en   (lz_en),
    .seg     (seg),
    .an      (an),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Two reset edges; returns on the falling edge where rst is released.
  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle load pulse; returns one falling edge after the capture edge.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Bounded wait for busy to fall and then for the first digit-0 slot.
  task automatic wait_commit(output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (an !== 4'b1110 && n < 110) begin
      @(negedge clk);
      n++;
    end
    ok = (an === 4'b1110);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state busy=%b an=%b seg=%h expected busy=0 an=1111 seg=ff", busy, an, seg);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || an !== 4'b1111 || seg !== 8'hFF) begin
        errors++;
        $display("FAIL idle_dark cyc=%0d busy=%b an=%b seg=%h expected busy=0 an=1111 seg=ff", i, busy, an, seg);
      end
    end
  endtask

  task automatic test_load_decode();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    bit ok;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    apply_reset();
    repeat (3) @(negedge clk);
    do_load(16'h12AF, 4'b0100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_busy busy=%b expected 1", busy);
    end
    wait_commit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_commit_timeout an=%b busy=%b expected an=1110 busy=0", an, busy);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (an !== an_tab[(i % 16) / 4] || seg !== seg_tab[(i % 16) / 4]) begin
        errors++;
        $display("FAIL decode_walk cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                 i, an, seg, an_tab[(i % 16) / 4], seg_tab[(i % 16) / 4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] an_tab [4];
    bit ok;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    apply_reset();
    do_load(16'h1111, 4'b0000);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_first busy=%b expected 1", busy);
    end
    do_load(16'h2222, 4'b0000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_second busy=%b expected 1", busy);
    end
    wait_commit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_commit_timeout an=%b busy=%b expected an=1110 busy=0", an, busy);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an !== an_tab[i / 4] || seg !== 8'hA4) begin
        errors++;
        $display("FAIL b2b_walk cyc=%0d an=%b seg=%h expected an=%b seg=a4", i, an, seg, an_tab[i / 4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    bit ok;
    apply_reset();
    lz_en = 1'b1;
    do_load(16'h0030, 4'b0000);
    wait_commit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lz_commit_timeout an=%b busy=%b expected an=1110 busy=0", an, busy);
    end
    an_tab  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    seg_tab = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an !== an_tab[i / 4] || seg !== seg_tab[i / 4]) begin
        errors++;
        $display("FAIL lz_0030 cyc=%0d an=%b seg=%h expected an=%b seg=%h", i, an, seg, an_tab[i / 4], seg_tab[i / 4]);
      end
      @(negedge clk);
    end
    do_load(16'h0000, 4'b0000);
    wait_commit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lz_zero_timeout an=%b busy=%b expected an=1110 busy=0", an, busy);
    end
    an_tab  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    seg_tab = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an !== an_tab[i / 4] || seg !== seg_tab[i / 4]) begin
        errors++;
        $display("FAIL lz_0000 cyc=%0d an=%b seg=%h expected an=%b seg=%h", i, an, seg, an_tab[i / 4], seg_tab[i / 4]);
      end
      @(negedge clk);
    end
    lz_en = 1'b0;
  endtask

  task automatic test_blink();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    bit ok;
    bit shown;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    apply_reset();
    blink_en = 4'b0001;
    do_load(16'h4321, 4'b0000);
    wait_commit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL blink_commit_timeout an=%b busy=%b expected an=1110 busy=0", an, busy);
    end
    // First displayed frame follows boundary 1: on, off, off, on, on, off, off, on.
    for (int f = 0; f < 8; f++) begin
      shown = ((((f + 1) / 2) % 2) == 0);
      for (int c = 0; c < 16; c++) begin
        if (c / 4 == 0 && !shown) begin
          exp_an  = 4'b1111;
          exp_seg = 8'hFF;
        end else begin
          exp_an  = an_tab[c / 4];
          exp_seg = seg_tab[c / 4];
        end
        checks++;
        if (an !== exp_an || seg !== exp_seg) begin
          errors++;
          $display("FAIL blink frame=%0d cyc=%0d an=%b seg=%h expected an=%b seg=%h", f, c, an, seg, exp_an, exp_seg);
        end
        @(negedge clk);
      end
    end
    blink_en = 4'b0000;
  endtask

  task automatic test_boundary_load();
    apply_reset();
    do_load(16'h0000, 4'b0000);
    repeat (13) @(negedge clk);
    value = 16'h0008;
    dp    = 4'b0000;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL boundary_busy busy=%b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 8'hC0) begin
      errors++;
      $display("FAIL boundary_old an=%b seg=%h expected an=1110 seg=c0", an, seg);
    end
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL boundary_busy_held busy=%b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL boundary_second_commit busy=%b expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 8'h80) begin
      errors++;
      $display("FAIL boundary_new an=%b seg=%h expected an=1110 seg=80", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'h5555;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    checks++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== 8'hFF) begin
      errors++;
      $display("FAIL midreset_state busy=%b an=%b seg=%h expected busy=0 an=1111 seg=ff", busy, an, seg);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || an !== 4'b1111) begin
        errors++;
        $display("FAIL midreset_no_capture cyc=%0d busy=%b an=%b expected busy=0 an=1111", i, busy, an);
      end
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_load(16'h0005, 4'b0000);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL midreset_slot_timing cycles=%0d expected 14", n);
    end
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 8'h92) begin
      errors++;
      $display("FAIL midreset_digit0 an=%b seg=%h expected an=1110 seg=92", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_load_decode();
    test_back_to_back();
    test_leading_zero();
    test_blink();
    test_boundary_load();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
